// File: rtl/fire_squeeze_ofm_writer_if.sv
// fire_squeeze_ofm_writer_if
// Bus between the squeeze MAC array (master side) and the OFM writer (slave
// side), which serialises each captured pixel vector into the next layer's
// activation RAM write port.
//   layer_en     : layer enable from the producer side
//   sample/ofm   : one-cycle capture pulse with the DSP_NO-word pixel vector
//   wr_en/addr/data : activation RAM write port driven by the writer
//   ram_feedback : one-cycle pulse once every pixel of the layer is written
//   busy         : writer is draining or still holds captured data
//   overflow     : sticky flag, a sample had to be dropped
interface fire_squeeze_ofm_writer_if #(
  parameter int unsigned WOUT   = 8,
  parameter int unsigned DSP_NO = 112,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(WOUT*WOUT*DSP_NO)
);
  logic              layer_en;
  logic              sample;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              ram_feedback;
  logic              busy;
  logic              overflow;

  modport master (
    output layer_en, sample, ofm,
    input  wr_en, wr_addr, wr_data, ram_feedback, busy, overflow
  );

  modport slave (
    input  layer_en, sample, ofm,
    output wr_en, wr_addr, wr_data, ram_feedback, busy, overflow
  );
endinterface

// File: rtl/fire_squeeze_ofm_writer.sv
// fire_squeeze_ofm_writer
// Captures a DSP_NO-wide output vector on each sample pulse and writes it to
// the activation RAM one word per cycle at pix*DSP_NO+ch. After the last of
// WOUT*WOUT pixels, pulses ram_feedback once and parks in DONE until
// layer_en drops.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   ofm_if     : fire_squeeze_ofm_writer_if.slave (layer_en, sample, ofm in;
//                wr_en, wr_addr, wr_data, ram_feedback, busy, overflow out)
// Build option: OFM_WR_DOUBLE_BUF_EN selects two ping-pong capture banks so a
// sample arriving mid-drain is queued; otherwise a single bank is used and such
// a sample is dropped with overflow set.
module fire_squeeze_ofm_writer #(
  parameter int unsigned WOUT   = 8,
  parameter int unsigned DSP_NO = 112,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = $clog2(WOUT*WOUT*DSP_NO)
) (
  input logic                      clk,
  input logic                      rst_n,
  fire_squeeze_ofm_writer_if.slave ofm_if
);
  localparam int unsigned NPIX  = WOUT*WOUT;
  localparam int unsigned PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(NPIX-1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(DSP_NO-1);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FEEDBACK, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]  wr_data_q, wr_data_d;
  logic              fb_q, fb_d;
  logic              busy_q, busy_d;
  logic              cap_en;  // load ofm into a bank this edge
  logic              direct;  // first word comes straight from ofm
  logic              clr;

`ifdef OFM_WR_DOUBLE_BUF_EN
  logic              rd_q, rd_d;      // bank being drained
  logic              pend_q, pend_d;  // bank ~rd holds a queued pixel
  logic              cap_sel;
  logic [WIDTH-1:0]  bank_q [0:1][0:DSP_NO-1];
`else
  logic [WIDTH-1:0]  bank_q [0:DSP_NO-1];
`endif

  // Output registers are loaded from the next-state values so the word for
  // (pix_d, ch_d) is on the RAM port in the same cycle the FSM is there; this
  // gives the one-cycle sample-to-first-write latency.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    ch_d    = ch_q;
    ovf_d   = ovf_q;
    cap_en  = 1'b0;
    direct  = 1'b0;
    clr     = 1'b0;
`ifdef OFM_WR_DOUBLE_BUF_EN
    rd_d    = rd_q;
    pend_d  = pend_q;
    cap_sel = rd_q;
`endif
    if (!ofm_if.layer_en) begin
      state_d = S_IDLE;
      pix_d   = '0;
      ch_d    = '0;
      clr     = 1'b1;
`ifdef OFM_WR_DOUBLE_BUF_EN
      rd_d    = 1'b0;
      pend_d  = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ofm_if.sample) begin
            cap_en  = 1'b1;
            direct  = 1'b1;
            ch_d    = '0;
            state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (ch_q == CH_LAST) begin
            ch_d = '0;
            if (pix_q == PIX_LAST) begin
              state_d = S_FEEDBACK;
`ifdef OFM_WR_DOUBLE_BUF_EN
              pend_d  = 1'b0;
`endif
            end else begin
              pix_d = pix_q + 1'b1;
`ifdef OFM_WR_DOUBLE_BUF_EN
              // The draining bank is fully read out by now, so a sample on
              // this cycle can refill it while the queued bank starts.
              if (pend_q) begin
                rd_d = ~rd_q;
                if (ofm_if.sample) begin
                  cap_en  = 1'b1;
                  cap_sel = rd_q;
                end else begin
                  pend_d = 1'b0;
                end
              end else if (ofm_if.sample) begin
                cap_en = 1'b1;
                direct = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
`else
              if (ofm_if.sample) begin
                cap_en = 1'b1;
                direct = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
`endif
            end
          end else begin
            ch_d = ch_q + 1'b1;
            if (ofm_if.sample) begin
`ifdef OFM_WR_DOUBLE_BUF_EN
              if (!pend_q) begin
                cap_en  = 1'b1;
                cap_sel = ~rd_q;
                pend_d  = 1'b1;
              end else begin
                ovf_d = 1'b1;
              end
`else
              ovf_d = 1'b1;
`endif
            end
          end
        end
        S_FEEDBACK: state_d = S_DONE;
        default: ;
      endcase
    end

    wr_en_d   = (state_d == S_DRAIN);
    wr_addr_d = '0;
    wr_data_d = '0;
    if (wr_en_d) begin
      wr_addr_d = ADDR_W'(pix_d) * ADDR_W'(DSP_NO) + ADDR_W'(ch_d);
`ifdef OFM_WR_DOUBLE_BUF_EN
      wr_data_d = direct ? ofm_if.ofm[0] : bank_q[rd_d][ch_d];
`else
      wr_data_d = direct ? ofm_if.ofm[0] : bank_q[ch_d];
`endif
    end
    fb_d   = (state_d == S_FEEDBACK);
`ifdef OFM_WR_DOUBLE_BUF_EN
    busy_d = wr_en_d || pend_d;
`else
    busy_d = wr_en_d;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pix_q     <= '0;
      ch_q      <= '0;
      ovf_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fb_q      <= 1'b0;
      busy_q    <= 1'b0;
`ifdef OFM_WR_DOUBLE_BUF_EN
      rd_q      <= 1'b0;
      pend_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pix_q     <= pix_d;
      ch_q      <= ch_d;
      ovf_q     <= ovf_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fb_q      <= fb_d;
      busy_q    <= busy_d;
`ifdef OFM_WR_DOUBLE_BUF_EN
      rd_q      <= rd_d;
      pend_q    <= pend_d;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      for (int unsigned i = 0; i < DSP_NO; i++) begin
`ifdef OFM_WR_DOUBLE_BUF_EN
        bank_q[0][i] <= '0;
        bank_q[1][i] <= '0;
`else
        bank_q[i] <= '0;
`endif
      end
    end else if (cap_en) begin
      for (int unsigned i = 0; i < DSP_NO; i++) begin
`ifdef OFM_WR_DOUBLE_BUF_EN
        bank_q[cap_sel][i] <= ofm_if.ofm[i];
`else
        bank_q[i] <= ofm_if.ofm[i];
`endif
      end
    end
  end

  assign ofm_if.wr_en        = wr_en_q;
  assign ofm_if.wr_addr      = wr_addr_q;
  assign ofm_if.wr_data      = wr_data_q;
  assign ofm_if.ram_feedback = fb_q;
  assign ofm_if.busy         = busy_q;
  assign ofm_if.overflow     = ovf_q;
endmodule

// File: tb/tb_fire_squeeze_ofm_writer.sv
// tb_fire_squeeze_ofm_writer
// Scoreboard bench for fire_squeeze_ofm_writer: every accepted sample pushes
// its DSP_NO expected writes (cycle, address, data) into a queue; a monitor
// pops and compares them on the falling edge. Honours OFM_WR_DOUBLE_BUF_EN.
module tb_fire_squeeze_ofm_writer;
  localparam int WOUT   = 8;
  localparam int DSP_NO = 112;
  localparam int WIDTH  = 16;
  localparam int NPIX   = WOUT*WOUT;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  fire_squeeze_ofm_writer_if #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH)) bus ();

  fire_squeeze_ofm_writer #(.WOUT(WOUT), .DSP_NO(DSP_NO), .WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ofm_if (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int addr; int data; } exp_t;
  exp_t sb_q[$];

  int n_writes, n_fb, last_addr;
  int exp_pix, drain_end, last_start, exp_fb;
  bit ovf_exp;

  typedef struct { int gap; int exp_writes; int exp_ovf; } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pat(input int base, input int pix, input int i);
    return (base + pix*256 + i) & 16'hFFFF;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic flush_model();
    sb_q.delete();
    exp_pix    = 0;
    drain_end  = -10;
    last_start = -10;
    exp_fb     = -1;
    n_writes   = 0;
    n_fb       = 0;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.layer_en = 1'b0;
    bus.sample   = 1'b0;
    ovf_exp      = 1'b0;
    flush_model();
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
  endtask

  // Drive one sample pulse in the current cycle and predict its writes.
  task automatic send(input int base);
    int c0, start;
    bit accept;
    c0 = cyc;
    for (int i = 0; i < DSP_NO; i++) bus.ofm[i] = WIDTH'(pat(base, exp_pix, i));
    bus.sample = 1'b1;
    if (bus.layer_en && exp_pix < NPIX) begin
`ifdef OFM_WR_DOUBLE_BUF_EN
      accept = (last_start <= c0 + 1);
`else
      accept = (drain_end <= c0);
`endif
      if (accept) begin
        start = (drain_end + 1 > c0 + 1) ? drain_end + 1 : c0 + 1;
        for (int k = 0; k < DSP_NO; k++)
          sb_q.push_back('{start + k, exp_pix*DSP_NO + k, pat(base, exp_pix, k)});
        drain_end  = start + DSP_NO - 1;
        last_start = start;
        if (exp_pix == NPIX-1) exp_fb = drain_end + 1;
        exp_pix++;
      end else begin
        ovf_exp = 1'b1;
      end
    end
    wait_cycles(1);
    bus.sample = 1'b0;
  endtask

  task automatic drop_layer();
    int c;
    c = cyc;
    bus.layer_en = 1'b0;
    while (sb_q.size() > 0 && sb_q[$].cyc > c) void'(sb_q.pop_back());
    exp_pix    = 0;
    drain_end  = -10;
    last_start = -10;
    exp_fb     = -1;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || bus.busy) && k < budget) begin
      wait_cycles(1);
      k++;
    end
    check("drain_within_budget", sb_q.size(), 0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en) begin
        n_writes++;
        last_addr = int'(bus.wr_addr);
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: wr_addr=%0d wr_data=%0d, required no write (cycle %0d)",
                   bus.wr_addr, bus.wr_data, cyc);
        end else begin
          e = sb_q.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("wr_addr", int'(bus.wr_addr), e.addr);
          check("wr_data", int'(bus.wr_data), e.data);
        end
      end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        e = sb_q.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL missing_write: wr_en=0, required write addr=%0d at cycle %0d", e.addr, e.cyc);
      end
      if (bus.ram_feedback) begin
        n_fb++;
        check("ram_feedback_cycle", cyc, exp_fb);
      end
    end
  endtask

  initial begin
    vecs[0] = '{112, 224, 0};
    vecs[1] = '{200, 224, 0};
    vecs[2] = '{113, 224, 0};
`ifdef OFM_WR_DOUBLE_BUF_EN
    vecs[3] = '{50,  224, 0};
    vecs[4] = '{111, 224, 0};
`else
    vecs[3] = '{50,  112, 1};
    vecs[4] = '{111, 112, 1};
`endif

    fork
      monitor();
    join_none

    rst_n        = 1'b0;
    bus.layer_en = 1'b0;
    bus.sample   = 1'b0;
    for (int i = 0; i < DSP_NO; i++) bus.ofm[i] = '0;
    ovf_exp = 1'b0;
    flush_model();
    wait_cycles(2);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_wr_addr", int'(bus.wr_addr), 0);
    check("rst_wr_data", int'(bus.wr_data), 0);
    check("rst_ram_feedback", int'(bus.ram_feedback), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_overflow", int'(bus.overflow), 0);

    // Single pixel, ofm[i]=i+1.
    do_reset();
    bus.layer_en = 1'b1;
    wait_cycles(6);
    send(1);
    wait_cycles(DSP_NO-1);
    check("t1_busy_last_write", int'(bus.busy), 1);
    check("t1_wr_en_last_write", int'(bus.wr_en), 1);
    wait_cycles(1);
    check("t1_busy_after", int'(bus.busy), 0);
    check("t1_wr_en_after", int'(bus.wr_en), 0);
    wait_cycles(5);
    check("t1_writes", n_writes, DSP_NO);
    check("t1_no_feedback", n_fb, 0);
    check("t1_sb_empty", sb_q.size(), 0);

    // Full layer, 64 pixels 513 cycles apart, then one extra sample.
    do_reset();
    bus.layer_en = 1'b1;
    wait_cycles(2);
    for (int p = 0; p < NPIX; p++) begin
      send(0);
      wait_cycles(512);
    end
    check("t2_writes", n_writes, NPIX*DSP_NO);
    check("t2_last_addr", last_addr, NPIX*DSP_NO - 1);
    check("t2_feedback_pulses", n_fb, 1);
    check("t2_overflow", int'(bus.overflow), 0);
    check("t2_sb_empty", sb_q.size(), 0);
    send(0);
    wait_cycles(200);
    check("t2_extra_writes", n_writes, NPIX*DSP_NO);
    check("t2_extra_overflow", int'(bus.overflow), 0);
    check("t2_extra_feedback", n_fb, 1);

    // Two-sample spacing table.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      bus.layer_en = 1'b1;
      wait_cycles(2);
      send(r*3 + 5);
      wait_cycles(vecs[r].gap - 1);
      send(r*3 + 7);
      wait_drain(600);
      wait_cycles(3);
      check("vec_writes", n_writes, vecs[r].exp_writes);
      check("vec_overflow", int'(bus.overflow), vecs[r].exp_ovf);
      check("vec_overflow_model", int'(bus.overflow), int'(ovf_exp));
    end

    // layer_en dropped at ch=40, then restart.
    do_reset();
    bus.layer_en = 1'b1;
    wait_cycles(2);
    send(9);
    wait_cycles(40);
    drop_layer();
    wait_cycles(1);
    check("abort_wr_en", int'(bus.wr_en), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_writes", n_writes, 41);
    bus.layer_en = 1'b1;
    wait_cycles(2);
    send(11);
    wait_drain(300);
    check("abort_restart_writes", n_writes, 41 + DSP_NO);
    check("abort_overflow", int'(bus.overflow), 0);

    // Overflow, then asynchronous reset mid-drain.
    do_reset();
    bus.layer_en = 1'b1;
    wait_cycles(2);
    send(13);
    wait_cycles(9);
    send(17);
    wait_cycles(9);
    send(19);
    wait_cycles(9);
    check("r_overflow_set", int'(bus.overflow), int'(ovf_exp));
    rst_n = 1'b0;
    #1;
    check("r_wr_en", int'(bus.wr_en), 0);
    check("r_wr_addr", int'(bus.wr_addr), 0);
    check("r_wr_data", int'(bus.wr_data), 0);
    check("r_ram_feedback", int'(bus.ram_feedback), 0);
    check("r_busy", int'(bus.busy), 0);
    check("r_overflow_cleared", int'(bus.overflow), 0);
    flush_model();
    ovf_exp = 1'b0;
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(1);
    send(23);
    wait_drain(300);
    check("r_restart_writes", n_writes, DSP_NO);
    check("r_restart_overflow", int'(bus.overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fire_squeeze_ofm_writer.md
# fire_squeeze_ofm_writer

Downstream consumer of a fire squeeze layer's output. On each one-cycle `sample` pulse it captures the full `DSP_NO`-wide output-feature-map vector and serialises it into the next layer's activation RAM, one word per cycle. After the last output pixel is written it pulses `ram_feedback`, closing the layer handshake. Sits between the squeeze MAC array and the activation RAM write port.

## Interface
- `WOUT`, 8: output spatial dimension; the layer produces `WOUT*WOUT` pixels.
- `DSP_NO`, 112: channels per pixel, equal to the width of `ofm`.
- `WIDTH`, 16: word width.
- `ADDR_W`, `$clog2(WOUT*WOUT*DSP_NO)`: RAM address width (13 at defaults).

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `layer_en`  in  1  layer enable; when low, the block returns to IDLE and clears its counters.
- `sample`  in  1  one-cycle pulse; `ofm` is valid in the same cycle.
- `ofm`  in  `WIDTH` x [0:`DSP_NO`-1]  output vector for one pixel.
- `wr_en`  out  1  RAM write strobe.
- `wr_addr`  out  `ADDR_W`  RAM address = `pix*DSP_NO + ch`.
- `wr_data`  out  `WIDTH`  RAM write data; `ofm[ch]` passed through unchanged.
- `ram_feedback`  out  1  one-cycle pulse when all `WOUT*WOUT` pixels are written.
- `busy`  out  1  high in DRAIN or while any bank holds data.
- `overflow`  out  1  sticky flag; set when a sample is dropped.

## Operation
- Counters:
  - `pix`: 0..`WOUT*WOUT`-1.
  - `ch`: 0..`DSP_NO`-1.
  - Capture bank(s): `DSP_NO` x `WIDTH` registers.
- States:
  - IDLE: `sample && layer_en` → capture `ofm` into the bank, set `ch=0`, go to DRAIN.
  - DRAIN:
    - Each cycle assert `wr_en`, drive `wr_addr=pix*DSP_NO+ch` and `wr_data=bank[ch]`, then increment `ch`.
    - At `ch==DSP_NO-1`:
      - `pix==WOUT*WOUT-1` → go to FEEDBACK.
      - Otherwise increment `pix`.
      - If a pending bank exists, or `sample` is high this cycle, stay in DRAIN with `ch=0` (back-to-back). Otherwise go to IDLE.
  - FEEDBACK: assert `ram_feedback` for one cycle, then go to DONE.
  - DONE:
    - `sample` ignored: no write, no overflow.
    - Leave DONE only on `rst_n` low or `layer_en` low; both lead to IDLE with `pix=0`. The producer may emit extra samples after the last pixel; these are dropped silently.
- A sample that cannot be captured sets `overflow` and is dropped; `pix` does not advance for it.
- `layer_en` low at any point: abort the drain, `wr_en` goes low the next cycle, clear `pix`/`ch`/banks, go to IDLE. `overflow` is preserved; only reset clears it.
- `sample` while `layer_en` is low is ignored.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `ram_feedback=0`, `busy=0`, `overflow=0`; state IDLE, `pix=0`, `ch=0`.
- All outputs are registered.
- Sample at cycle t → first write at cycle t+1 (`ch=0`) → last write at t+`DSP_NO`.
- For the final pixel, `ram_feedback` is high at cycle t+`DSP_NO`+1.
- Sample coinciding with the last drain cycle (`ch==DSP_NO-1`): accepted in both configurations. Its first write is in the next cycle, with no bubble.
- Sample during DRAIN at any earlier `ch`: behaviour depends on configuration (below).
- Write throughput is 1 word/cycle; the producer sample period is `CHIN+1` cycles (≥ `DSP_NO`), so overflow indicates a system fault.

## Configuration
- `OFM_WR_DOUBLE_BUF_EN` defined:
  - Two capture banks in ping-pong.
  - A sample during DRAIN is captured into the free bank and drained immediately after the current bank.
  - A sample while both banks are full sets `overflow` and is dropped.
- Undefined:
  - Single bank.
  - A sample during DRAIN before `ch==DSP_NO-1` sets `overflow` and is dropped.

## Test plan
- Reset, then set `layer_en=1` and pulse `sample` at t=10 with `ofm[i]=i+1` → writes at t=11..122, `wr_addr` 0..111, `wr_data` 1..112; `busy` low at t=123; no `ram_feedback`.
- 64 samples, 513 cycles apart, with `ofm[i]=pix*256+i` → 7168 writes, last `wr_addr`=7167; `ram_feedback` high for exactly one cycle at last-write+1; a 65th sample afterwards produces no write and no `overflow`.
- Two samples 112 cycles apart (second lands on `ch==111`) → 224 contiguous `wr_en` cycles, addresses 0..223, `overflow=0`.
- Two samples 50 cycles apart:
  - With the macro: 224 writes, second pixel data intact, `overflow=0`.
  - Without the macro: 112 writes, `overflow=1`.
- Drop `layer_en` at `ch=40` → `wr_en` low the next cycle; re-enable and sample → writes restart at `wr_addr=0`.
- Assert `rst_n=0` mid-DRAIN → all outputs zero asynchronously, state IDLE, `overflow` cleared.
